// File: rtl/nr_divider_pipe_ctrl.sv
// nr_divider_pipe_ctrl: multi-cycle Newton-Raphson unsigned divider with
// valid/ready handshakes on both sides. The divisor is normalised to [0.5,1),
// its reciprocal is refined for ITERS cycles, and the quotient estimate is
// corrected to the exact floor result. Divide-by-zero returns all-ones / dividend.
// Optional build macro NRD_CORR_STATS_EN adds the corr_steps output.
module nr_divider_pipe_ctrl #(
  parameter int WIDTH = 8,
  parameter int ITERS = 3,
  parameter int FRAC  = WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`ifdef NRD_CORR_STATS_EN
  ,
  output logic [2:0]       corr_steps
`endif
);

  localparam int XW  = FRAC + 2;           // reciprocal in (1,2], FRAC fraction bits
  localparam int PW  = 2 * FRAC + 4;       // signed product width for the refinement
  localparam int MW  = 2 * WIDTH + FRAC;   // dividend * reciprocal
  localparam int QW  = WIDTH + 2;          // quotient estimate with correction headroom
  localparam int RW  = 2 * WIDTH + 3;      // signed residue, wide enough for any estimate
  localparam int LZW = $clog2(WIDTH);
  localparam int CW  = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);
  localparam logic [PW-1:0] ONE = PW'(1) << FRAC;
  localparam logic [PW-1:0] C48 = PW'((64'd48 << FRAC) / 64'd17);
  localparam logic [PW-1:0] C32 = PW'((64'd32 << FRAC) / 64'd17);

  // Smallest k with log2(17) * 2^k >= WIDTH+1 (log2(17) ~= 4.087).
  function automatic int min_iters(input int w);
    int k;
    k = 0;
    while ((4087 << k) < 1000 * (w + 1)) k = k + 1;
    return k;
  endfunction

  if (WIDTH < 4 || WIDTH > 32) begin : g_width_chk
    $error("nr_divider_pipe_ctrl: WIDTH must be in 4..32");
  end
  if (FRAC < WIDTH) begin : g_frac_chk
    $error("nr_divider_pipe_ctrl: FRAC must be at least WIDTH");
  end
  if (ITERS < min_iters(WIDTH)) begin : g_iters_chk
    $error("nr_divider_pipe_ctrl: ITERS too small for WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_EST, S_ITER, S_MUL, S_CORR, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dsr_q, dsr_d;
  logic [LZW-1:0]    lz_q, lz_d;
  logic [FRAC-1:0]   dnorm_q, dnorm_d;
  logic [XW-1:0]     x_q, x_d;
  logic [QW-1:0]     qhat_q, qhat_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;
`ifdef NRD_CORR_STATS_EN
  logic [2:0]        steps_q, steps_d;
  logic [2:0]        steps_val;
`endif

  logic [LZW-1:0]        lz_calc;
  logic [XW-1:0]         x0_val, x_next;
  logic [QW-1:0]         qhat_val, q_fix;
  logic signed [PW-1:0]  d_s, x_s, dx_s, e_s, xe_s;
  logic signed [RW-1:0]  dsr_s, r0, r_fix;
  logic                  corr_ok;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
`ifdef NRD_CORR_STATS_EN
  assign corr_steps  = steps_q;
`endif

  // Leading-zero count of the latched divisor (never zero when used).
  always_comb begin
    logic found;
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    lz_calc = '0;
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (dsr_q[i]) found = 1'b1;
        else          lz_calc = lz_calc + 1'b1;
      end
    end
  end

  // Arithmetic for each datapath step: estimate, refinement, quotient, correction.
  always_comb begin
    // X0 = 48/17 - 32/17 * D
    x0_val = XW'(C48 - ((C32 * PW'(dnorm_q)) >> FRAC));

    // X' = X + X*(1 - D*X), products truncated to FRAC bits
    d_s    = $signed(PW'(dnorm_q));
    x_s    = $signed(PW'(x_q));
    dx_s   = (d_s * x_s) >>> FRAC;
    e_s    = $signed(ONE) - dx_s;
    xe_s   = (x_s * e_s) >>> FRAC;
    x_next = XW'(x_s + xe_s);

    // D carries the divisor with WIDTH fraction bits, so undo both scalings.
    qhat_val = QW'((MW'(dvd_q) * MW'(x_q)) >> (FRAC + WIDTH - int'(lz_q)));

    // Residue is kept wider than the final remainder so an estimate that is
    // two steps high or low cannot wrap before it is corrected.
    dsr_s = $signed(RW'(dsr_q));
    r0    = $signed(RW'(dvd_q)) - $signed(RW'(qhat_q) * RW'(dsr_q));
    q_fix = qhat_q;
    r_fix = r0;
`ifdef NRD_CORR_STATS_EN
    steps_val = 3'b000;
`endif
    // NOTE: blocking assignments here chain the two correction steps within one cycle.
    if (r0 < 0) begin
      q_fix = q_fix - 1'b1;
      r_fix = r_fix + dsr_s;
`ifdef NRD_CORR_STATS_EN
      steps_val = 3'b101;
`endif
      if (r_fix < 0) begin
        q_fix = q_fix - 1'b1;
        r_fix = r_fix + dsr_s;
`ifdef NRD_CORR_STATS_EN
        steps_val = 3'b110;
`endif
      end
    end else if (r0 >= dsr_s) begin
      q_fix = q_fix + 1'b1;
      r_fix = r_fix - dsr_s;
`ifdef NRD_CORR_STATS_EN
      steps_val = 3'b001;
`endif
      if (r_fix >= dsr_s) begin
        q_fix = q_fix + 1'b1;
        r_fix = r_fix - dsr_s;
`ifdef NRD_CORR_STATS_EN
        steps_val = 3'b010;
`endif
      end
    end
    corr_ok = (r_fix >= 0) && (r_fix < dsr_s);
  end

  // Next-state and next-register values for the controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    lz_d    = lz_q;
    dnorm_d = dnorm_q;
    x_d     = x_q;
    qhat_d  = qhat_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef NRD_CORR_STATS_EN
    steps_d = steps_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dsr_d = divisor;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
`ifdef NRD_CORR_STATS_EN
            steps_d = 3'b000;
`endif
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        lz_d    = lz_calc;
        dnorm_d = FRAC'(dsr_q << lz_calc) << (FRAC - WIDTH);
        state_d = S_EST;
      end
      S_EST: begin
        x_d     = x0_val;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        x_d   = x_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_MUL;
      end
      S_MUL: begin
        qhat_d  = qhat_val;
        state_d = S_CORR;
      end
      S_CORR: begin
        quot_d  = WIDTH'(q_fix);
        rem_d   = WIDTH'(r_fix);
        dbz_d   = 1'b0;
`ifdef NRD_CORR_STATS_EN
        steps_d = steps_val;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state and visible result registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef NRD_CORR_STATS_EN
      steps_q <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef NRD_CORR_STATS_EN
      steps_q <= steps_d;
`endif
    end
  end

  // Working registers for the current division.
  // NOTE: left unreset on purpose; each is written before any state reads it.
  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    dvd_q   <= dvd_d;
    dsr_q   <= dsr_d;
    lz_q    <= lz_d;
    dnorm_q <= dnorm_d;
    x_q     <= x_d;
    qhat_q  <= qhat_d;
  end

`ifndef SYNTHESIS
  // A quotient estimate more than two away from exact means the reciprocal is broken.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_CORR) begin
      assert (corr_ok) else $error("nr_divider_pipe_ctrl: estimate beyond +/-2 correction");
    end
  end
`endif

endmodule
